// File: rtl/led_bus_arbiter_if.sv
// Purpose : bundles the LED-bus requester inputs and arbiter outputs into one port.
// Latency : none (wires only).
// Backpressure: none; the arbiter is the slave, the requester side is the master.
// Signals : req/data   requester side -> arbiter
//           gnt/busy/owner_id/led_out   arbiter -> requesters and ledr pins
interface led_bus_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 10
) ();
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data;
  logic [N_REQ-1:0]        gnt;
  logic                    busy;
  logic [IW-1:0]           owner_id;
  logic [DATA_W-1:0]       led_out;

  modport master (output req, data, input gnt, busy, owner_id, led_out);
  modport slave  (input req, data, output gnt, busy, owner_id, led_out);
endinterface

// File: rtl/led_bus_arbiter.sv
// Purpose : round-robin arbiter sharing the board LED bus between N_REQ requesters.
// Latency : req -> gnt 1 cycle; owner data -> led_out 1 cycle.
// Backpressure: none; requesters hold req until granted, owner data is sampled every grant cycle.
// Ports   : clk, reset (sync, active-high), bus.slave:
//           req[N_REQ], data[N_REQ*DATA_W] in; gnt (one-hot), busy, owner_id, led_out out.
module led_bus_arbiter #(
  parameter int                N_REQ    = 3,
  parameter int                DATA_W   = 10,
  parameter int                MIN_HOLD = 4,
  parameter int                MAX_HOLD = 1024,
  parameter logic [DATA_W-1:0] IDLE_VAL = '0
) (
  input  logic           clk,
  input  logic           reset,
  led_bus_arbiter_if.slave bus
);

  localparam int HOLD_MAX = (MIN_HOLD > MAX_HOLD) ? MIN_HOLD : MAX_HOLD;
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam int IW       = $clog2(N_REQ);

  localparam logic [HW-1:0]    HOLD_SAT = HW'(HOLD_MAX);
  localparam logic [HW-1:0]    MIN_M1   = HW'(MIN_HOLD - 1);
  localparam logic [HW-1:0]    MAX_M1   = HW'(MAX_HOLD - 1);
  localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);
  localparam logic [IW-1:0]    RR_RST   = IW'(N_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [DATA_W-1:0] led_q, led_d;

  logic [IW:0]       idle_pick, hand_pick;
  logic              others_req, min_ok, preempt, release_now;

  // Round-robin search starting after 'base', looking at 'span' candidates.
  // The index is computed modulo N_REQ so non power-of-two counts wrap correctly.
  // Result: {found, index}.
  function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] r,
                                          input logic [IW-1:0]    base,
                                          input int               span);
    logic          found;
    logic [IW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(base) + k) % N_REQ);
      if (!found && (k <= span) && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    led_d   = led_q;

    // IDLE searches all requesters from rr_ptr+1; a handoff skips the owner.
    idle_pick  = rr_pick(bus.req, rr_q, N_REQ);
    hand_pick  = rr_pick(bus.req, owner_q, N_REQ - 1);
    others_req = |(bus.req & ~gnt_q);
    min_ok     = (hold_q >= MIN_M1);
    // '>=' rather than '==': hold_cnt may already sit saturated past MAX_HOLD-1
    // when a late requester arrives, and it must still be able to preempt.
    preempt     = (MAX_HOLD != 0) && (hold_q >= MAX_M1) && others_req;
    release_now = (!bus.req[owner_q] && min_ok) || preempt;

    case (state_q)
      IDLE: begin
        if (idle_pick[IW]) begin
          state_d = GRANT;
          gnt_d   = ONE << idle_pick[IW-1:0];
          owner_d = idle_pick[IW-1:0];
          hold_d  = '0;
        end
      end
      GRANT: begin
        led_d  = bus.data[int'(owner_q)*DATA_W +: DATA_W];
        hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
        if (release_now) begin
          rr_d = owner_q;
          if (hand_pick[IW]) begin
            // Direct handoff: no idle cycle between owners.
            gnt_d   = ONE << hand_pick[IW-1:0];
            owner_d = hand_pick[IW-1:0];
            hold_d  = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      rr_q    <= RR_RST;
      hold_q  <= '0;
      led_q   <= IDLE_VAL;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      led_q   <= led_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.busy     = busy_q;
  assign bus.owner_id = owner_q;
  assign bus.led_out  = led_q;

endmodule

// File: tb/tb_led_bus_arbiter.sv
module tb_led_bus_arbiter;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  led_bus_arbiter_if #(.N_REQ(3), .DATA_W(10)) bus3 ();
  led_bus_arbiter_if #(.N_REQ(5), .DATA_W(10)) bus5 ();

  led_bus_arbiter #(.N_REQ(3), .DATA_W(10), .MIN_HOLD(4), .MAX_HOLD(16), .IDLE_VAL(10'h000))
    dut3 (.clk(clk), .reset(reset), .bus(bus3));
  led_bus_arbiter #(.N_REQ(5), .DATA_W(10), .MIN_HOLD(4), .MAX_HOLD(16), .IDLE_VAL(10'h000))
    dut5 (.clk(clk), .reset(reset), .bus(bus5));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Expected grant transitions: new gnt value, new owner, cycles since previous change (0 = don't care).
  typedef struct {
    logic [2:0] gnt;
    int         owner;
    int         gap;
  } gev_t;

  gev_t        gq[$];
  logic [9:0]  lq[$];
  logic        ev_en, inv_en;
  logic [2:0]  prev_gnt;
  logic [9:0]  prev_led;
  int          last_chg;
  int          w3[3], w5[5];
  int          max3, max5;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_le(input string nm, input int act, input int lim);
    n_cmp++;
    if (act > lim) begin
      n_bad++;
      $display("FAIL %s: got %0d expected <= %0d", nm, act, lim);
    end
  endtask

  task automatic exp_g(input logic [2:0] g, input int o, input int gap);
    gev_t e;
    e.gnt = g; e.owner = o; e.gap = gap;
    gq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation whenever gnt or led_out changes.
  always @(negedge clk) begin
    if (ev_en) begin
      if (bus3.gnt !== prev_gnt) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", 32'(bus3.gnt), 32'(prev_gnt));
        end else begin
          gev_t e;
          e = gq.pop_front();
          chk("gnt", 32'(bus3.gnt), 32'(e.gnt));
          if (e.gnt != 3'b000) chk("owner_id", 32'(bus3.owner_id), 32'(e.owner));
          if (e.gap != 0) chk("gnt_gap", 32'(cyc - last_chg), 32'(e.gap));
        end
        prev_gnt = bus3.gnt;
        last_chg = cyc;
      end
      if (bus3.led_out !== prev_led) begin
        if (lq.size() == 0) chk("led_unexpected", 32'(bus3.led_out), 32'(prev_led));
        else chk("led_out", 32'(bus3.led_out), 32'(lq.pop_front()));
        prev_led = bus3.led_out;
      end
    end
  end

  // Invariants and starvation tracking on both instances.
  always @(negedge clk) begin
    if (inv_en) begin
      chk("gnt3_onehot0", 32'($onehot0(bus3.gnt)), 32'd1);
      chk("busy3_eq_or", 32'(bus3.busy), 32'(|bus3.gnt));
      chk("gnt5_onehot0", 32'($onehot0(bus5.gnt)), 32'd1);
      chk("busy5_eq_or", 32'(bus5.busy), 32'(|bus5.gnt));
      for (int i = 0; i < 3; i++) begin
        if (bus3.req[i] === 1'b1 && bus3.gnt[i] === 1'b0) w3[i]++; else w3[i] = 0;
        if (w3[i] > max3) max3 = w3[i];
      end
      for (int i = 0; i < 5; i++) begin
        if (bus5.req[i] === 1'b1 && bus5.gnt[i] === 1'b0) w5[i]++; else w5[i] = 0;
        if (w5[i] > max5) max5 = w5[i];
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    ev_en = 1'b0; inv_en = 1'b0;
    max3 = 0; max5 = 0;
    foreach (w3[i]) w3[i] = 0;
    foreach (w5[i]) w5[i] = 0;
    reset = 1'b1;
    bus3.req = 3'b111;
    bus3.data = {10'h0, 10'h155, 10'h2A1};
    bus5.req = '0;
    bus5.data = '0;

    // 1: reset with all requests held
    step(3);
    @(negedge clk);
    chk("rst_gnt", 32'(bus3.gnt), 32'd0);
    chk("rst_busy", 32'(bus3.busy), 32'd0);
    chk("rst_owner", 32'(bus3.owner_id), 32'd0);
    chk("rst_led", 32'(bus3.led_out), 32'd0);
    prev_gnt = bus3.gnt; prev_led = bus3.led_out; last_chg = cyc;
    ev_en = 1'b1; inv_en = 1'b1;
    exp_g(3'b001, 0, 0);
    lq.push_back(10'h2A1);
    exp_g(3'b000, 0, 4);
    step(1);
    reset = 1'b0;
    step(1);
    bus3.req = 3'b000;
    step(8);

    // 2: single request, req dropped during the minimum hold
    exp_g(3'b010, 1, 0);
    lq.push_back(10'h155);
    exp_g(3'b000, 0, 4);
    bus3.req = 3'b010;
    step(2);
    bus3.req = 3'b000;
    step(6);

    // 3: round-robin after a reset pulse; direct handoffs, no idle cycles
    lq.push_back(10'h000);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    bus3.data = {10'h033, 10'h022, 10'h011};
    exp_g(3'b001, 0, 0);
    exp_g(3'b010, 1, 6);
    exp_g(3'b100, 2, 6);
    exp_g(3'b001, 0, 6);
    exp_g(3'b000, 0, 4);
    lq.push_back(10'h011);
    lq.push_back(10'h022);
    lq.push_back(10'h033);
    lq.push_back(10'h011);
    bus3.req = 3'b111;
    step(1);
    for (int o = 0; o < 3; o++) begin
      step(5);
      bus3.req[o] = 1'b0;
      step(1);
      bus3.req[o] = 1'b1;
    end
    bus3.req = 3'b000;
    step(6);

    // 4: preemption at MAX_HOLD, then a lone owner keeps the bus
    bus3.data = {10'h0F0, 10'h022, 10'h3C0};
    exp_g(3'b001, 0, 0);
    exp_g(3'b100, 2, 16);
    exp_g(3'b001, 0, 4);
    exp_g(3'b000, 0, 41);
    lq.push_back(10'h3C0);
    lq.push_back(10'h0F0);
    lq.push_back(10'h3C0);
    bus3.req = 3'b001;
    step(6);
    bus3.req = 3'b101;
    step(11);
    bus3.req = 3'b001;
    step(4);
    step(40);
    bus3.req = 3'b000;
    step(6);

    // 5: reset mid-grant; requests during reset are ignored, requester 0 wins after
    exp_g(3'b100, 2, 0);
    lq.push_back(10'h0F0);
    exp_g(3'b000, 0, 3);
    lq.push_back(10'h000);
    exp_g(3'b001, 0, 0);
    lq.push_back(10'h3C0);
    exp_g(3'b000, 0, 4);
    bus3.req = 3'b100;
    step(3);
    reset = 1'b1;
    bus3.req = 3'b111;
    step(1);
    @(negedge clk);
    chk("midrst_busy", 32'(bus3.busy), 32'd0);
    chk("midrst_owner", 32'(bus3.owner_id), 32'd0);
    chk("midrst_led", 32'(bus3.led_out), 32'd0);
    step(1);
    reset = 1'b0;
    step(1);
    bus3.req = 3'b000;
    step(8);
    chk("gnt_events_left", 32'(gq.size()), 32'd0);
    chk("led_events_left", 32'(lq.size()), 32'd0);
    ev_en = 1'b0;

    // 6: random traffic; a waiting requester keeps req until granted
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (bus3.req[i] && bus3.gnt[i]) begin
          if ($urandom_range(7) == 0) bus3.req[i] = 1'b0;
        end else if (!bus3.req[i]) begin
          if ($urandom_range(3) == 0) bus3.req[i] = 1'b1;
        end
        bus3.data[i*10 +: 10] = 10'($urandom);
      end
      for (int i = 0; i < 5; i++) begin
        if (bus5.req[i] && bus5.gnt[i]) begin
          if ($urandom_range(7) == 0) bus5.req[i] = 1'b0;
        end else if (!bus5.req[i]) begin
          if ($urandom_range(3) == 0) bus5.req[i] = 1'b1;
        end
        bus5.data[i*10 +: 10] = 10'($urandom);
      end
      step(1);
    end
    bus3.req = '0;
    bus5.req = '0;
    step(4);
    inv_en = 1'b0;
    chk_le("wait3_bound", max3, (3 - 1) * 16 + 3);
    chk_le("wait5_bound", max5, (5 - 1) * 16 + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
